// File: rtl/r5fp_idiv_pkg.sv
// r5fp_idiv_pkg: shared state type and iteration-count helper for the radix-4 divider
package r5fp_idiv_pkg;
  typedef enum logic {IDLE, BUSY} idiv_state_e;
  function automatic int idiv_iters(input int w);
    return w / 2;
  endfunction
endpackage

// File: rtl/r5fp_idiv_r4_step.sv
// r5fp_idiv_r4_step: one radix-4 restoring step, picks the largest digit q with q*D <= 4R
module r5fp_idiv_r4_step #(
  parameter int W = 26
) (
  input  logic [W-1:0] R,
  input  logic [W-1:0] D,
  output logic [1:0]   q,
  output logic [W-1:0] R_next
);
  logic [W+1:0] p, d1, d2, d3;
  logic [W-1:0] sub;
  always_comb begin
    p = {R, 2'b00};
    d1 = {2'b00, D};
    d2 = {1'b0, D, 1'b0};
    d3 = d1 + d2;
    q = (d3 <= p) ? 2'd3 : (d2 <= p) ? 2'd2 : (d1 <= p) ? 2'd1 : 2'd0;
    sub = (q == 2'd3) ? d3[W-1:0] : (q == 2'd2) ? d2[W-1:0] : (q == 2'd1) ? d1[W-1:0] : '0;
    R_next = p[W-1:0] - sub;
  end
endmodule

// File: rtl/r5fp_idiv_radix4.sv
// r5fp_idiv_radix4: iterative radix-4 fractional divider, Q = floor(N*2^W/D), 2 bits per cycle
module r5fp_idiv_radix4
  import r5fp_idiv_pkg::*;
#(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] idiv_N,
  input  logic [W-1:0] idiv_D,
  input  logic         idiv_strobe,
  output logic [W-1:0] idiv_Quo,
  output logic [W-1:0] idiv_Rem,
  output logic         idiv_done,
  output logic         idiv_ready
);
  localparam int ITERS = idiv_iters(W);
  localparam int CW = $clog2(ITERS + 1);
  if (W % 2 != 0 || W < 4) begin : g_bad_width
    $error("r5fp_idiv_radix4: W must be even and at least 4");
  end
  idiv_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] r_q, q_q, d_q, r_next;
  logic [1:0] digit;
  logic start, last;
  r5fp_idiv_r4_step #(.W(W)) u_step (
    .R(r_q),
    .D(d_q),
    .q(digit),
    .R_next(r_next)
  );
  always_comb begin
    start = (state == IDLE) && idiv_strobe;
    last = (state == BUSY) && (cnt == CW'(1));
    state_nxt = start ? BUSY : last ? IDLE : state;
    idiv_ready = (state == IDLE);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      idiv_done <= 1'b0;
    end else begin
      state <= state_nxt;
      idiv_done <= last;
      if (start) begin
        r_q <= idiv_N;
        q_q <= '0;
        d_q <= idiv_D;
        cnt <= CW'(ITERS);
      end else if (state == BUSY) begin
        r_q <= r_next;
        q_q <= {q_q[W-3:0], digit};
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign idiv_Quo = q_q;
  assign idiv_Rem = r_q;
endmodule
